// File: rtl/fwd_hazard_scoreboard.sv
// rtl/fwd_hazard_scoreboard.sv - in-flight destination scoreboard driving EX forwarding selects and load-use stall
module fwd_hazard_scoreboard #(
   parameter  int REG_AW         = 5,
   parameter  int NUM_SRC        = 2,
   parameter  int DEPTH          = 3,
   parameter  int LOAD_FWD_STAGE = 3,
   localparam int SELW           = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic                      id_regwrite,
   input  logic                      id_is_load,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic                      pipe_hold,
   input  logic                      flush,
   output logic                      stall,
   output logic [NUM_SRC*SELW-1:0]   fwd_sel,
   output logic [31:0]               stall_cnt
);

   logic [DEPTH:1]      entV;
   logic [DEPTH:1]      entLd;
   logic [REG_AW-1:0]   entRd [1:DEPTH];

   logic [NUM_SRC*SELW-1:0] nextSel;
   logic [NUM_SRC-1:0]      srcHazard;
   logic                    bubble;

   // Scan oldest-to-youngest so the youngest match overwrites; entry DEPTH is
   // skipped because it reaches the register file before the consumer reads it.
   always_comb begin
      nextSel   = '0;
      srcHazard = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            if (id_rs_used[s] && entV[k] &&
                (entRd[k] == id_rs[s*REG_AW +: REG_AW]) &&
                (id_rs[s*REG_AW +: REG_AW] != '0)) begin
               nextSel[s*SELW +: SELW] = SELW'(k + 1);
               srcHazard[s]            = entLd[k] && ((k + 1) < LOAD_FWD_STAGE);
            end
         end
      end
   end

   assign stall  = id_valid && !pipe_hold && (|srcHazard);
   assign bubble = flush || stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entV      <= '0;
         entLd     <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            entRd[k] <= '0;
         end
         fwd_sel   <= '0;
         stall_cnt <= '0;
      end else if (!pipe_hold) begin
         for (int k = DEPTH; k >= 2; k--) begin
            entV[k]  <= entV[k-1];
            entLd[k] <= entLd[k-1];
            entRd[k] <= entRd[k-1];
         end
         entV[1]  <= id_valid && id_regwrite && (id_rd != '0) && !bubble;
         entRd[1] <= id_rd;
         entLd[1] <= id_is_load;
         fwd_sel  <= bubble ? '0 : nextSel;
         // A stall that coincides with flush still counts.
         if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb/tb_fwd_hazard_scoreboard.sv - directed and randomized checks of fwd_hazard_scoreboard against a queue model
module tb_fwd_hazard_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        idValid, idRegwrite, idIsLoad, pipeHold, flush;
   logic [4:0]  idRd;
   logic [9:0]  idRs;
   logic [1:0]  idRsUsed;
   logic        stall;
   logic [3:0]  fwdSel;
   logic [31:0] stallCnt;

   logic        pValid, pRegwrite, pIsLoad, pHold, pFlush;
   logic [4:0]  pRd;
   logic [14:0] pRs;
   logic [2:0]  pUsed;
   logic        pStall;
   logic [8:0]  pFwd;
   logic [31:0] pCnt;

   int checks;
   int errors;

   typedef struct {
      logic       w;
      logic [4:0] rd;
      logic       ld;
   } ent_t;

   ent_t        pipe[$];
   logic [3:0]  expFwd;
   logic [31:0] expCnt;

   fwd_hazard_scoreboard #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3), .LOAD_FWD_STAGE(3)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_regwrite(idRegwrite),
      .id_is_load(idIsLoad), .id_rd(idRd), .id_rs(idRs), .id_rs_used(idRsUsed),
      .pipe_hold(pipeHold), .flush(flush), .stall(stall), .fwd_sel(fwdSel),
      .stall_cnt(stallCnt)
   );

   fwd_hazard_scoreboard #(.REG_AW(5), .NUM_SRC(3), .DEPTH(5), .LOAD_FWD_STAGE(4)) dutP (
      .clk(clk), .rst_n(rst_n), .id_valid(pValid), .id_regwrite(pRegwrite),
      .id_is_load(pIsLoad), .id_rd(pRd), .id_rs(pRs), .id_rs_used(pUsed),
      .pipe_hold(pHold), .flush(pFlush), .stall(pStall), .fwd_sel(pFwd),
      .stall_cnt(pCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Default-configuration reference: pipe[0] is EX, pipe[1] MEM, pipe[2] WB.
   function automatic void modelEval(output logic expStall, output logic [3:0] sel);
      logic [1:0] hz;
      logic [4:0] rs;
      sel = '0;
      hz  = '0;
      for (int s = 0; s < 2; s++) begin
         rs = idRs[s*5 +: 5];
         for (int i = 0; i < pipe.size() && i < 2; i++) begin
            if (idRsUsed[s] && pipe[i].w && pipe[i].rd == rs && rs != 0) begin
               sel[s*2 +: 2] = 2'(i + 2);
               hz[s]         = pipe[i].ld && ((i + 2) < 3);
               break;
            end
         end
      end
      expStall = idValid && !pipeHold && (hz != 0);
   endfunction

   task automatic cyc(input string tag);
      logic       es;
      logic [3:0] ns;
      ent_t       e;
      #1;
      modelEval(es, ns);
      chk({tag, "/stall"}, stall, es);
      @(posedge clk);
      if (!pipeHold) begin
         e.w  = idValid && idRegwrite && (idRd != 0) && !es && !flush;
         e.rd = idRd;
         e.ld = idIsLoad;
         pipe.push_front(e);
         if (pipe.size() > 3) void'(pipe.pop_back());
         expFwd = (flush || es) ? 4'd0 : ns;
         if (es && expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 1;
      end
      #1;
      chk({tag, "/fwd"}, fwdSel, expFwd);
      chk({tag, "/cnt"}, stallCnt, expCnt);
      @(negedge clk);
   endtask

   task automatic drv(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                      input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
      idValid = v; idRegwrite = rw; idIsLoad = ld; idRd = rd;
      idRs = {rs1, rs0}; idRsUsed = used;
   endtask

   task automatic pdrv(input logic ld, input logic [4:0] rd, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] used);
      pValid = 1'b1; pRegwrite = 1'b1; pIsLoad = ld; pRd = rd;
      pRs = {rs2, rs1, rs0}; pUsed = used;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] r [0:2];
      checks = 0; errors = 0;
      rst_n = 1'b0; pipeHold = 0; flush = 0; pHold = 0; pFlush = 0;
      drv(0, 0, 0, 0, 0, 0, 0);
      pValid = 0; pRegwrite = 0; pIsLoad = 0; pRd = 0; pRs = 0; pUsed = 0;
      expFwd = 0; expCnt = 0;
      repeat (2) @(negedge clk);
      chk("rst_fwd", fwdSel, 0);
      chk("rst_stall", stall, 0);
      chk("rst_cnt", stallCnt, 0);
      chk("rstP_cnt", pCnt, 0);
      rst_n = 1'b1;

      // ALU chains
      drv(1, 1, 0, 5, 1, 2, 2'b11);   cyc("add5");
      drv(1, 1, 0, 6, 5, 5, 2'b11);   cyc("sub6");
      chk("alu_b2b", fwdSel, 4'b1010);
      drv(1, 1, 0, 9, 1, 2, 2'b11);   cyc("add9");
      drv(0, 0, 0, 0, 0, 0, 0);       cyc("nop1");
      drv(1, 1, 0, 14, 9, 9, 2'b11);  cyc("sub14");
      chk("alu_gap1", fwdSel, 4'b1111);
      drv(1, 1, 0, 10, 1, 2, 2'b11);  cyc("add10");
      drv(0, 0, 0, 0, 0, 0, 0);       cyc("nop2a");
      cyc("nop2b");
      drv(1, 1, 0, 15, 10, 10, 2'b11); cyc("sub15");
      chk("alu_gap2", fwdSel, 4'b0000);

      // Load-use
      drv(1, 1, 1, 7, 0, 0, 2'b00);   cyc("lw7");
      drv(1, 1, 0, 8, 7, 1, 2'b11);
      #1 chk("lu_stall", stall, 1);
      cyc("lu_a");
      chk("lu_cnt", stallCnt, 1);
      chk("lu_bubble", fwdSel, 0);
      cyc("lu_b");
      chk("lu_fwd", fwdSel, 4'b0011);

      // Youngest wins, x0 never matches
      drv(1, 1, 0, 3, 0, 0, 2'b00);   cyc("x3a");
      drv(1, 1, 0, 3, 0, 0, 2'b00);   cyc("x3b");
      drv(1, 1, 0, 16, 3, 0, 2'b01);  cyc("use3");
      chk("youngest", fwdSel, 4'b0010);
      drv(1, 1, 1, 0, 0, 0, 2'b00);   cyc("lw0");
      drv(1, 1, 0, 17, 0, 0, 2'b11);
      #1 chk("x0_stall", stall, 0);
      cyc("use0");
      chk("x0_fwd", fwdSel, 0);

      // Hold during a load-use stall, then flush
      drv(1, 1, 1, 11, 17, 0, 2'b01); cyc("lw11");
      chk("lw11_fwd", fwdSel, 4'b0010);
      drv(1, 1, 0, 18, 11, 11, 2'b11);
      #1 chk("hold_pre_stall", stall, 1);
      pipeHold = 1'b1;
      repeat (4) begin
         cyc("hold");
         chk("hold_stall", stall, 0);
         chk("hold_fwd", fwdSel, 4'b0010);
         chk("hold_cnt", stallCnt, 1);
      end
      pipeHold = 1'b0;
      #1 chk("unhold_stall", stall, 1);
      cyc("unhold_a");
      chk("unhold_cnt", stallCnt, 2);
      cyc("unhold_b");
      chk("unhold_fwd", fwdSel, 4'b1111);
      drv(1, 1, 0, 12, 0, 0, 2'b00);
      flush = 1'b1;
      cyc("flush");
      chk("flush_fwd", fwdSel, 0);
      flush = 1'b0;
      drv(1, 1, 0, 19, 12, 12, 2'b11); cyc("after_flush");
      chk("flush_consumer", fwdSel, 0);

      // Asynchronous reset mid-stall
      drv(1, 1, 1, 13, 19, 0, 2'b01); cyc("lw13");
      chk("lw13_fwd", fwdSel, 4'b0010);
      drv(1, 1, 0, 20, 13, 0, 2'b01);
      #1 chk("pre_rst_stall", stall, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_stall", stall, 0);
      chk("async_rst_fwd", fwdSel, 0);
      chk("async_rst_cnt", stallCnt, 0);
      @(negedge clk);
      pipe.delete(); expFwd = 0; expCnt = 0;
      rst_n = 1'b1;
      #1 chk("post_rst_stall", stall, 0);
      cyc("post_rst");
      chk("post_rst_fwd", fwdSel, 0);

      // Randomized traffic against the model
      repeat (400) begin
         drv($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 4)),
             5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 2'($urandom));
         pipeHold = ($urandom_range(0, 7) == 0);
         flush    = ($urandom_range(0, 7) == 0);
         cyc("rand");
      end
      pipeHold = 0; flush = 0;
      drv(0, 0, 0, 0, 0, 0, 0);

      // DEPTH=5, NUM_SRC=3, LOAD_FWD_STAGE=4
      for (int s = 0; s < 3; s++) begin
         pdrv(1, 5'(21 + s), 0, 0, 0, 3'b000); step();
         r[0] = 1; r[1] = 1; r[2] = 1;
         r[s] = 5'(21 + s);
         pdrv(0, 5'(26 + s), r[0], r[1], r[2], 3'b111);
         #1 chk("p_stall1", pStall, 1);
         step();
         chk("p_bubble1", pFwd, 0);
         #1 chk("p_stall2", pStall, 1);
         step();
         #1 chk("p_stall3", pStall, 0);
         step();
         chk("p_sel", pFwd, 9'(4) << (3 * s));
         chk("p_cnt", pCnt, 32'(2 * (s + 1)));
      end
      pdrv(1, 5'd24, 0, 0, 0, 3'b000); step();
      pdrv(0, 5'd29, 24, 1, 1, 3'b111);
      #1 chk("sat_stall1", pStall, 1);
      force dutP.stall_cnt = 32'hFFFF_FFFF;
      step();
      release dutP.stall_cnt;
      #1 chk("sat_stall2", pStall, 1);
      step();
      chk("sat_cnt", pCnt, 32'hFFFF_FFFF);
      step();
      chk("sat_sel", pFwd, 9'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
